// File: rtl/sentinel_wb_arb_pkg.sv
// Shared types and default widths for the Sentinel two-master Wishbone arbiter.
package sentinel_wb_arb_pkg;

   localparam int unsigned DefAddrW   = 30;
   localparam int unsigned DefDataW   = 32;
   localparam int unsigned DefTimeout = 15;

   // Bus ownership state; encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StOwn0 = 2'b01,
      StOwn1 = 2'b10
   } arb_state_e;

   // Index of a requesting master (round-robin pointer type).
   typedef logic master_idx_t;

   localparam master_idx_t Master0 = 1'b0;
   localparam master_idx_t Master1 = 1'b1;

endpackage

// File: rtl/sentinel_wb_watchdog.sv
// Stall watchdog: counts owner cycles without an ack and flags expiry after TIMEOUT of them.
// Only instantiated when SENTINEL_WB_ARB_TIMEOUT_EN is defined.
module sentinel_wb_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,  // owner holds cyc this cycle
   input  logic ack_i,     // owner's beat is acked this cycle
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Expiry fires in the cycle the count of prior stall cycles hits TIMEOUT.
   always_comb begin
      expire_o = active_i && (cnt_q == CntW'(TIMEOUT));
      if (!active_i || ack_i || expire_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sentinel_wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter for the Sentinel bus.
// Round-robin grant per cyc, held for the whole cycle, back-to-back handoff without bubbles.
// Optional hung-slave kill: define SENTINEL_WB_ARB_TIMEOUT_EN.
module sentinel_wb_arbiter
   import sentinel_wb_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic                clk,
   input  logic                rst,
   // master 0 (core)
   input  logic                m0__cyc,
   input  logic                m0__stb,
   input  logic                m0__we,
   input  logic [ADDR_W-1:0]   m0__adr,
   input  logic [DATA_W/8-1:0] m0__sel,
   input  logic [DATA_W-1:0]   m0__dat_w,
   output logic [DATA_W-1:0]   m0__dat_r,
   output logic                m0__ack,
   output logic                m0__err,
   // master 1 (debug / DMA)
   input  logic                m1__cyc,
   input  logic                m1__stb,
   input  logic                m1__we,
   input  logic [ADDR_W-1:0]   m1__adr,
   input  logic [DATA_W/8-1:0] m1__sel,
   input  logic [DATA_W-1:0]   m1__dat_w,
   output logic [DATA_W-1:0]   m1__dat_r,
   output logic                m1__ack,
   output logic                m1__err,
   // slave
   output logic                s__cyc,
   output logic                s__stb,
   output logic                s__we,
   output logic [ADDR_W-1:0]   s__adr,
   output logic [DATA_W/8-1:0] s__sel,
   output logic [DATA_W-1:0]   s__dat_w,
   input  logic [DATA_W-1:0]   s__dat_r,
   input  logic                s__ack,
   // debug
   output logic [1:0]          gnt
);

   arb_state_e  state_q, state_d;
   master_idx_t last_q, last_d;

   logic own0;
   logic own1;
   logic owner_cyc;
   logic expire;
   logic ack_ok;

   // Decode current ownership and the owner's raw cyc.
   always_comb begin
      own0      = (state_q == StOwn0);
      own1      = (state_q == StOwn1);
      owner_cyc = (own0 & m0__cyc) | (own1 & m1__cyc);
   end

`ifdef SENTINEL_WB_ARB_TIMEOUT_EN
   logic owner_stb;
   logic raw_ack;

   assign owner_stb = (own0 & m0__stb) | (own1 & m1__stb);
   assign raw_ack   = owner_cyc & owner_stb & s__ack;

   sentinel_wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .active_i (owner_cyc),
      .ack_i    (raw_ack),
      .expire_o (expire)
   );
`else
   // No watchdog: a hung slave holds the bus until its master gives up.
   logic unused_timeout;
   assign expire         = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   // Slave port: combinational copy of the owner, zero when idle or being killed.
   always_comb begin
      s__cyc   = 1'b0;
      s__stb   = 1'b0;
      s__we    = 1'b0;
      s__adr   = '0;
      s__sel   = '0;
      s__dat_w = '0;
      unique case (state_q)
         StOwn0: begin
            s__cyc   = m0__cyc;
            s__stb   = m0__stb;
            s__we    = m0__we;
            s__adr   = m0__adr;
            s__sel   = m0__sel;
            s__dat_w = m0__dat_w;
         end
         StOwn1: begin
            s__cyc   = m1__cyc;
            s__stb   = m1__stb;
            s__we    = m1__we;
            s__adr   = m1__adr;
            s__sel   = m1__sel;
            s__dat_w = m1__dat_w;
         end
         default: ;
      endcase
      if (expire) begin
         s__cyc = 1'b0;
         s__stb = 1'b0;
      end
   end

   // Return path: ack/err only to the owner, read data broadcast.
   always_comb begin
      ack_ok    = s__cyc & s__stb & s__ack;
      m0__dat_r = s__dat_r;
      m1__dat_r = s__dat_r;
      m0__ack   = own0 & ack_ok;
      m1__ack   = own1 & ack_ok;
      m0__err   = own0 & expire;
      m1__err   = own1 & expire;
      gnt       = {own1, own0};
   end

   // Arbitration: grant from idle, hold while owner cyc stays high, hand off on release.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (m0__cyc && (!m1__cyc || last_q == Master1)) begin
               state_d = StOwn0;
               last_d  = Master0;
            end else if (m1__cyc) begin
               state_d = StOwn1;
               last_d  = Master1;
            end
         end
         StOwn0: begin
            if (expire) begin
               state_d = StIdle;
            end else if (!owner_cyc) begin
               if (m1__cyc) begin
                  state_d = StOwn1;
                  last_d  = Master1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StOwn1: begin
            if (expire) begin
               state_d = StIdle;
            end else if (!owner_cyc) begin
               if (m0__cyc) begin
                  state_d = StOwn0;
                  last_d  = Master0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and round-robin pointer; reset favours master 0 on the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         last_q  <= Master1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: doc/sentinel_wb_arbiter.md
Name: sentinel_wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter that shares the Sentinel memory/peripheral bus.
- Master 0 is the Sentinel core bus port; master 1 is a secondary requester such as a debug or DMA engine.
- Grants by round-robin at transaction (cyc) granularity and holds the grant for the whole cycle.
- Muxes the winning master onto the slave port and routes ack back to that master only.

Parameters:
ADDR_W, 30, word address width (byte address bits [31:2])
DATA_W, 32, data width; SEL_W = DATA_W/8
TIMEOUT, 15, stall cycles before a hung transaction is killed (used only with the optional feature)

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous, active-high reset
m0__cyc/m0__stb/m0__we  in  1 each  master 0 control
m0__adr  in  ADDR_W  master 0 address
m0__sel  in  SEL_W  master 0 byte select
m0__dat_w  in  DATA_W  master 0 write data
m0__dat_r  out  DATA_W  read data to master 0
m0__ack  out  1  ack to master 0
m0__err  out  1  bus-error termination to master 0
m1__*  same set as m0__*, for master 1
s__cyc/s__stb/s__we  out  1 each  slave control
s__adr  out  ADDR_W  slave address
s__sel  out  SEL_W  slave byte select
s__dat_w  out  DATA_W  slave write data
s__dat_r  in  DATA_W  slave read data
s__ack  in  1  slave ack
gnt  out  2  one-hot current owner, for debug/formal

Behaviour:
- State register: IDLE, OWN0, OWN1. Round-robin pointer `last` (1 bit).
- Async reset puts state in IDLE and sets last=1, so m0 wins the first tie.
- Reset mid-transaction drops s__cyc immediately.
- IDLE:
  - Only m0__cyc high -> OWN0. Only m1__cyc high -> OWN1.
  - Both high -> grant !last.
  - Neither high -> stay in IDLE.
  - Grant is registered: 1-cycle arbitration latency from cyc to s__cyc.
- OWNx:
  - s__cyc/stb/we/adr/sel/dat_w are a combinational copy of master x.
  - mx__ack = s__ack. The other master's ack and err are 0.
  - last <= x when the grant is taken.
- Leaving OWNx: when mx__cyc falls, s__cyc falls in the same cycle (combinational).
  - Next state is OWN(other) if the other master's cyc is high that cycle, else IDLE.
  - This gives back-to-back handoff with no idle bubble.
- Grant hold: the owner keeps the grant across multiple stb/ack beats (block/locked sequences) for as long as its cyc stays high. There is no preemption.
- Read data: m0__dat_r and m1__dat_r both carry s__dat_r. Only the owner's ack qualifies it.
- Output reset values:
  - gnt = 2'b00.
  - All s__* = 0 (forced to 0 in IDLE, not X).
  - All m*__ack and m*__err = 0.
- Slave protocol:
  - s__ack is honoured only while s__cyc && s__stb.
  - Slaves take at least 1 cycle to ack; a same-cycle ack is not required to work.
- Simultaneous events: a master raising cyc while the other releases it is granted per the transition rule above, with no lost request.
- Invariants:
  - gnt is at most one-hot.
  - s__cyc implies gnt != 0.
  - m0__ack && m1__ack is never true.

Optional Feature:
SENTINEL_WB_ARB_TIMEOUT_EN
- Defined:
  - A 4-bit (clog2(TIMEOUT+1)) stall counter counts cycles with s__cyc && !s__ack. It clears on ack or in IDLE.
  - When the counter reaches TIMEOUT, for that cycle: pulse mx__err=1, force s__cyc=0 and s__stb=0, and go to IDLE (the round-robin pointer still favours the other master).
  - Err is a 1-cycle pulse and is never asserted together with ack.
- Undefined:
  - m0__err and m1__err are tied to 0 and no counter exists.
  - A hung slave holds the bus indefinitely.

Decomposition:
- Package sentinel_wb_arb_pkg holds:
  - the state enum type (IDLE/OWN0/OWN1);
  - the master index typedef;
  - the default width localparams.
- One natural sub-module, sentinel_wb_watchdog: the stall counter with its expiry pulse. It is instantiated only under the macro.

Test Plan:
- Single request: m0__cyc=stb=1, adr=0x100, slave acks after 2 cycles -> s__cyc rises 1 cycle later, m0__ack=1 exactly once, gnt=01, m1__ack=0 throughout.
- Tie after reset: m0 and m1 raise cyc in the same cycle -> gnt=01 first. After m0 drops cyc, gnt=10 on the next cycle with no IDLE bubble.
- Fairness: both request continuously for 4 transactions -> grant order m0,m1,m0,m1; no master is granted twice in a row while the other waits.
- Hold: m1 performs 3 stb/ack beats under one cyc while m0 is requesting -> gnt stays 10 for all 3 beats; m0 is granted only after m1__cyc falls.
- Reset mid-transfer: rst asserted in OWN0 with s__cyc=1 -> s__cyc=0 and gnt=00 in the same cycle. After release, the tie goes to m0.
- With SENTINEL_WB_ARB_TIMEOUT_EN and TIMEOUT=15, slave never acks -> m0__err pulses after 15 stall cycles, s__cyc drops that cycle, and a pending m1 is granted next.
